crystal_pixel_streamer: RTL and testbench
=========================================

// Module: crystal_pixel_streamer
// PURPOSE
//  Transmit side of the crystal_net pixel-input protocol. Host loads one 8-bit image into a local buffer, then pulses start.
//  Block streams INPUT_DIM pixels as valid/pixel/idx/last, one per cycle, then waits for the network's valid_out.
//  Latches predicted_class and reports completion. Sits between host/DMA logic and crystal_net.
// PARAMETERS
//  INPUT_DIM     784     pixels per image
//  DATA_WIDTH    16      signed pixel width driven to crystal_net
//  PIX_WIDTH     8       stored (unsigned) pixel width
//  TIMEOUT_CYC   4096    max cycles waiting for net_valid_out after px_last
// PORTS
//  clk               in   1                  clock
//  rst_n             in   1                  synchronous active-low reset
//  img_wr_en         in   1                  host pixel write strobe
//  img_wr_addr       in   $clog2(INPUT_DIM)  pixel index to write
//  img_wr_data       in   PIX_WIDTH          unsigned pixel value
//  wr_drop           out  1                  1-cycle pulse: write rejected (busy)
//  start             in   1                  1-cycle request to stream buffered image
//  busy              out  1                  high in STREAM/WAIT
//  px_valid          out  1                  to crystal_net valid_in
//  px_data           out  DATA_WIDTH         to crystal_net pixel_in (signed)
//  px_idx            out  $clog2(INPUT_DIM)  to crystal_net pixel_idx
//  px_last           out  1                  to crystal_net last_pixel
//  net_valid_out     in   1                  from crystal_net valid_out
//  net_pred_class    in   4                  from crystal_net predicted_class
//  result_valid      out  1                  1-cycle pulse: result_class updated
//  result_class      out  4                  last latched prediction
//  timeout_err       out  1                  sticky; set on wait timeout, cleared by start
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0; buffer contents not cleared.
//  FSM IDLE -> RD0 -> STREAM -> WAIT -> IDLE.
//   IDLE: start=1 -> RD0, clear timeout_err. start ignored outside IDLE.
//   RD0: issue buffer read addr 0 (1-cycle synchronous read). -> STREAM.
//   STREAM: px_valid=1 every cycle; px_idx=k, px_data=pixel[k], k=0..INPUT_DIM-1 with no gaps.
//    px_last=1 only with px_idx=INPUT_DIM-1. After the last beat -> WAIT. Read address runs one ahead.
//   WAIT: px_valid/px_last=0. net_valid_out=1 -> result_class<=net_pred_class, result_valid pulse next cycle, -> IDLE.
//    Wait counter reaches TIMEOUT_CYC -> timeout_err=1, result_class unchanged, -> IDLE.
//  Latency: start at edge N -> first px_valid after edge N+2; last beat after edge N+INPUT_DIM+1.
//  net_valid_out outside WAIT ignored (no result update).
//  Writes: accepted in IDLE only; in RD0/STREAM/WAIT dropped, wr_drop pulses next cycle; buffer unchanged.
//  img_wr_addr >= INPUT_DIM: dropped with wr_drop.
//  start same cycle as accepted write: write lands first; streamed image includes it.
//  Reset mid-stream: next cycle IDLE, px_valid=0, no px_last emitted; result_class=0.
//  px_data when px_valid=0: 0.
// CONFIGURATION
//  CRYSTAL_PIXEL_CENTER_EN defined: px_data = sign-extended (pixel - 2**(PIX_WIDTH-1)); 8-bit 0..255 -> -128..127.
//  Not defined: px_data = zero-extended pixel (0..255).
// STRUCTURE
//  crystal_pkg: INPUT_DIM, PIX_WIDTH, DATA_WIDTH defaults, IDX_W=$clog2(INPUT_DIM), state enum
//   (ST_IDLE, ST_RD0, ST_STREAM, ST_WAIT), centering function.
//  Sub-module crystal_img_ram: INPUT_DIM x PIX_WIDTH simple dual-port RAM,
//   1 write port, 1 synchronous read port, no reset; infers block RAM.
// TESTING
//  1 Load pixel[i]=i%256, no CENTER, start -> 784 contiguous beats, idx 0..783, data i%256,
//    px_last only at idx 783; first beat 2 cycles after start.
//  2 CENTER_EN, pixel[0]=0, [1]=128, [2]=255 -> px_data -128, 0, 127 (0xFF80, 0x0000, 0x007F).
//  3 Model net asserts valid_out with class 7 at 20 cycles after px_last -> result_class=7,
//    result_valid one pulse, busy low.
//  4 Net never responds, TIMEOUT_CYC=64 -> timeout_err=1 after 64 wait cycles, result_class kept,
//    next start clears it.
//  5 Write addr 5 during STREAM and addr 800 in IDLE -> both wr_drop, stream/readback pixel[5] unchanged;
//    start pulsed in STREAM ignored.
//  6 rst_n=0 at idx 300 -> px_valid=0 next cycle, state IDLE, new start streams from idx 0 with intact buffer.

Source files
------------

// File: rtl/crystal_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crystal_pkg
// Description : Shared constants, FSM state encoding and the pixel-centering
//               helper for the crystal_net pixel streamer.
// Revision    : 1.0 - initial release
// ============================================================================
package crystal_pkg;

  localparam int INPUT_DIM   = 784;
  localparam int PIX_WIDTH   = 8;
  localparam int DATA_WIDTH  = 16;
  localparam int TIMEOUT_CYC = 4096;
  localparam int IDX_W       = $clog2(INPUT_DIM);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD0    = 2'd1,
    ST_STREAM = 2'd2,
    ST_WAIT   = 2'd3
  } state_e;

  // Maps an unsigned pixel onto a range centred on zero (pixel - 2**(w-1)).
  // The 32-bit two's-complement result truncates to a sign-extended value.
  function automatic logic [31:0] center_pixel(input logic [31:0] pix, input int pix_w);
    logic [31:0] half;
    half = 32'd1 << (pix_w - 1);
    return pix - half;
  endfunction

endpackage
`default_nettype wire

// File: rtl/crystal_pixel_streamer_if.sv
`default_nettype none
// ============================================================================
// Module      : crystal_pixel_streamer_if
// Description : Pixel stream towards crystal_net plus the network's result
//               return path. master = streamer, slave = network.
// Revision    : 1.0 - initial release
// ============================================================================
interface crystal_pixel_streamer_if #(
  parameter int DATA_WIDTH = crystal_pkg::DATA_WIDTH,
  parameter int IDX_W      = crystal_pkg::IDX_W
);

  logic                  px_valid;
  logic [DATA_WIDTH-1:0] px_data;
  logic [IDX_W-1:0]      px_idx;
  logic                  px_last;
  logic                  net_valid_out;
  logic [3:0]            net_pred_class;

  modport master (
    output px_valid, px_data, px_idx, px_last,
    input  net_valid_out, net_pred_class
  );

  modport slave (
    input  px_valid, px_data, px_idx, px_last,
    output net_valid_out, net_pred_class
  );

endinterface
`default_nettype wire

// File: rtl/crystal_img_ram.sv
`default_nettype none
// ============================================================================
// Module      : crystal_img_ram
// Description : DEPTH x WIDTH simple dual-port image buffer, one write port,
//               one synchronous read port, no reset (block-RAM friendly).
// Revision    : 1.0 - initial release
// ============================================================================
module crystal_img_ram #(
  parameter int DEPTH = 784,
  parameter int WIDTH = 8,
  parameter int AW    = 10
) (
  input  wire logic             clk,
  input  wire logic             wr_en,
  input  wire logic [AW-1:0]    wr_addr,
  input  wire logic [WIDTH-1:0] wr_data,
  input  wire logic [AW-1:0]    rd_addr,
  output logic      [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Write port: caller guarantees wr_addr is in range when wr_en is high.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port: one-cycle registered read, no reset so it maps onto BRAM.
  always_ff @(posedge clk) begin
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/crystal_pixel_streamer.sv
`default_nettype none
// ============================================================================
// Module      : crystal_pixel_streamer
// Description : Buffers one image written by the host, streams it to
//               crystal_net one pixel per cycle on start, then waits for the
//               network's result (or a timeout) and latches the class.
//               Optional macro CRYSTAL_PIXEL_CENTER_EN: pixels are centred
//               around zero (pixel - 2**(PIX_WIDTH-1)) before being driven.
// Revision    : 1.0 - initial release
// ============================================================================
module crystal_pixel_streamer #(
  parameter int INPUT_DIM   = crystal_pkg::INPUT_DIM,
  parameter int DATA_WIDTH  = crystal_pkg::DATA_WIDTH,
  parameter int PIX_WIDTH   = crystal_pkg::PIX_WIDTH,
  parameter int TIMEOUT_CYC = crystal_pkg::TIMEOUT_CYC
) (
  input  wire logic                         clk,
  input  wire logic                         rst_n,
  input  wire logic                         img_wr_en,
  input  wire logic [$clog2(INPUT_DIM)-1:0] img_wr_addr,
  input  wire logic [PIX_WIDTH-1:0]         img_wr_data,
  output logic                              wr_drop,
  input  wire logic                         start,
  output logic                              busy,
  output logic                              result_valid,
  output logic [3:0]                        result_class,
  output logic                              timeout_err,
  crystal_pixel_streamer_if.master          net
);

  import crystal_pkg::*;

  localparam int AW    = $clog2(INPUT_DIM);
  localparam int MAXC  = (INPUT_DIM > TIMEOUT_CYC) ? INPUT_DIM : TIMEOUT_CYC;
  localparam int CNT_W = $clog2(MAXC);
  localparam logic [AW-1:0]    LAST_IDX = AW'(INPUT_DIM - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INPUT_DIM - 1);
  localparam logic [CNT_W-1:0] TO_CNT   = CNT_W'(TIMEOUT_CYC - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  px_valid_q, px_valid_d;
  logic [DATA_WIDTH-1:0] px_data_q, px_data_d;
  logic [AW-1:0]         px_idx_q, px_idx_d;
  logic                  px_last_q, px_last_d;
  logic                  result_valid_q, result_valid_d;
  logic [3:0]            result_class_q, result_class_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  wr_drop_q, wr_drop_d;

  logic                  wr_ok;
  logic [AW-1:0]         rd_addr;
  logic [PIX_WIDTH-1:0]  rd_data;
  logic [DATA_WIDTH-1:0] pix_ext;

  // Host writes land only while idle and in range; anything else is dropped.
  assign wr_ok     = img_wr_en && (state_q == ST_IDLE) && (img_wr_addr <= LAST_IDX);
  assign wr_drop_d = img_wr_en && !wr_ok;

  crystal_img_ram #(
    .DEPTH (INPUT_DIM),
    .WIDTH (PIX_WIDTH),
    .AW    (AW)
  ) u_img_ram (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (img_wr_addr),
    .wr_data (img_wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

`ifdef CRYSTAL_PIXEL_CENTER_EN
  assign pix_ext = DATA_WIDTH'(center_pixel(32'(rd_data), PIX_WIDTH));
`else
  assign pix_ext = DATA_WIDTH'(rd_data);
`endif

  // Next-state, buffer read address and next output values.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rd_addr        = '0;
    px_valid_d     = 1'b0;
    px_data_d      = '0;
    px_idx_d       = '0;
    px_last_d      = 1'b0;
    result_valid_d = 1'b0;
    result_class_d = result_class_q;
    timeout_err_d  = timeout_err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_RD0;
          timeout_err_d = 1'b0;
          cnt_d         = '0;
        end
      end
      ST_RD0: begin
        // Prefetch pixel 0 so the first beat has data on entry to STREAM.
        rd_addr = '0;
        cnt_d   = '0;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        px_valid_d = 1'b1;
        px_idx_d   = AW'(cnt_q);
        px_data_d  = pix_ext;
        if (cnt_q == LAST_CNT) begin
          px_last_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_WAIT;
        end else begin
          // Read address runs one beat ahead of the index being emitted.
          rd_addr = AW'(cnt_q + 1'b1);
          cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (net.net_valid_out) begin
          result_class_d = net.net_pred_class;
          result_valid_d = 1'b1;
          cnt_d          = '0;
          state_d        = ST_IDLE;
        end else if (cnt_q == TO_CNT) begin
          timeout_err_d = 1'b1;
          cnt_d         = '0;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      px_valid_q     <= 1'b0;
      px_data_q      <= '0;
      px_idx_q       <= '0;
      px_last_q      <= 1'b0;
      result_valid_q <= 1'b0;
      result_class_q <= '0;
      timeout_err_q  <= 1'b0;
      wr_drop_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      px_valid_q     <= px_valid_d;
      px_data_q      <= px_data_d;
      px_idx_q       <= px_idx_d;
      px_last_q      <= px_last_d;
      result_valid_q <= result_valid_d;
      result_class_q <= result_class_d;
      timeout_err_q  <= timeout_err_d;
      wr_drop_q      <= wr_drop_d;
    end
  end

  assign busy         = (state_q == ST_STREAM) || (state_q == ST_WAIT);
  assign wr_drop      = wr_drop_q;
  assign result_valid = result_valid_q;
  assign result_class = result_class_q;
  assign timeout_err  = timeout_err_q;

  assign net.px_valid = px_valid_q;
  assign net.px_data  = px_data_q;
  assign net.px_idx   = px_idx_q;
  assign net.px_last  = px_last_q;

endmodule
`default_nettype wire

// File: tb/tb_crystal_pixel_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_crystal_pixel_streamer
// Description : Self-checking bench for crystal_pixel_streamer: random and
//               patterned images against an array model of the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crystal_pixel_streamer;

  localparam int N_PIX = 784;
  localparam int TO    = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       img_wr_en;
  logic [9:0] img_wr_addr;
  logic [7:0] img_wr_data;
  logic       wr_drop;
  logic       start;
  logic       busy;
  logic       result_valid;
  logic [3:0] result_class;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  model [N_PIX];
  logic [3:0]  exp_class;
  logic [15:0] cap [3];

  always #5 clk = ~clk;

  crystal_pixel_streamer_if #(.DATA_WIDTH(16), .IDX_W(10)) net_if ();

  crystal_pixel_streamer #(
    .INPUT_DIM   (N_PIX),
    .DATA_WIDTH  (16),
    .PIX_WIDTH   (8),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .img_wr_en    (img_wr_en),
    .img_wr_addr  (img_wr_addr),
    .img_wr_data  (img_wr_data),
    .wr_drop      (wr_drop),
    .start        (start),
    .busy         (busy),
    .result_valid (result_valid),
    .result_class (result_class),
    .timeout_err  (timeout_err),
    .net          (net_if.master)
  );

  function automatic logic [15:0] exp_px(input logic [7:0] p);
`ifdef CRYSTAL_PIXEL_CENTER_EN
    int v;
    v = int'(p) - 128;
    return 16'(v);
`else
    return {8'h00, p};
`endif
  endfunction

  task automatic write_px(input int addr, input logic [7:0] d);
    img_wr_en   = 1'b1;
    img_wr_addr = 10'(addr);
    img_wr_data = d;
    @(posedge clk); #1;
    img_wr_en = 1'b0;
    if (addr < N_PIX) model[addr] = d;
  endtask

  task automatic load_image(input int kind);
    for (int i = 0; i < N_PIX; i++)
      write_px(i, (kind == 0) ? 8'(i % 256) : 8'($urandom));
    checks++;
    if (wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL load_no_drop: wr_drop=%0b want 0", wr_drop);
    end
  endtask

  // mode 0: plain stream; 1: write/start/net_valid injected mid-stream;
  // 2: reset asserted at beat 300 (returns early, DUT idle afterwards).
  task automatic stream_check(input int mode, input bit with_write, input logic [7:0] wdata);
    logic [15:0] want_d;
    logic        want_l;
    if (with_write) begin
      img_wr_en   = 1'b1;
      img_wr_addr = 10'd0;
      img_wr_data = wdata;
      model[0]    = wdata;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    img_wr_en = 1'b0;
    checks++;
    if (timeout_err !== 1'b0 || net_if.px_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_edge: timeout_err=%0b px_valid=%0b want 0 0", timeout_err, net_if.px_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (net_if.px_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_latency: px_valid=%0b one cycle after start edge, want 0", net_if.px_valid);
    end
    for (int k = 0; k < N_PIX; k++) begin
      @(posedge clk); #1;
      img_wr_en            = 1'b0;
      start                = 1'b0;
      net_if.net_valid_out = 1'b0;
      want_d = exp_px(model[k]);
      want_l = (k == N_PIX - 1);
      checks++;
      if (net_if.px_valid !== 1'b1 || net_if.px_idx !== 10'(k) || net_if.px_data !== want_d ||
          net_if.px_last !== want_l || busy !== 1'b1) begin
        errors++;
        $display("FAIL beat%0d: valid=%0b idx=%0d data=%h last=%0b busy=%0b want 1 %0d %h %0b 1",
                 k, net_if.px_valid, net_if.px_idx, net_if.px_data, net_if.px_last, busy,
                 k, want_d, want_l);
      end
      if (k < 3) cap[k] = net_if.px_data;
      if (mode == 1 && k == 10) begin
        img_wr_en             = 1'b1;
        img_wr_addr           = 10'd5;
        img_wr_data           = ~model[5];
        start                 = 1'b1;
        net_if.net_valid_out  = 1'b1;
        net_if.net_pred_class = exp_class + 4'd1;
      end
      if (mode == 1 && k == 11) begin
        checks++;
        if (wr_drop !== 1'b1 || result_valid !== 1'b0) begin
          errors++;
          $display("FAIL busy_write_drop: wr_drop=%0b result_valid=%0b want 1 0", wr_drop, result_valid);
        end
      end
      if (mode == 1 && k == 12) begin
        checks++;
        if (result_class !== exp_class || result_valid !== 1'b0) begin
          errors++;
          $display("FAIL net_valid_ignored: class=%0d rv=%0b want %0d 0", result_class, result_valid, exp_class);
        end
      end
      if (mode == 2 && k == 300) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (net_if.px_valid !== 1'b0 || net_if.px_last !== 1'b0 || net_if.px_data !== 16'h0 ||
            busy !== 1'b0 || result_class !== 4'd0) begin
          errors++;
          $display("FAIL reset_mid_stream: valid=%0b last=%0b data=%h busy=%0b class=%0d want 0 0 0 0 0",
                   net_if.px_valid, net_if.px_last, net_if.px_data, busy, result_class);
        end
        exp_class = 4'd0;
        rst_n     = 1'b1;
        @(posedge clk); #1;
        return;
      end
    end
  endtask

  task automatic test_result(input logic [3:0] cls, input int delay);
    for (int i = 1; i < delay; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        checks++;
        if (net_if.px_valid !== 1'b0 || net_if.px_last !== 1'b0 || net_if.px_data !== 16'h0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL wait_idle_bus: valid=%0b last=%0b data=%h busy=%0b want 0 0 0 1",
                   net_if.px_valid, net_if.px_last, net_if.px_data, busy);
        end
      end
    end
    net_if.net_valid_out  = 1'b1;
    net_if.net_pred_class = cls;
    @(posedge clk); #1;
    net_if.net_valid_out = 1'b0;
    checks++;
    if (result_valid !== 1'b1 || result_class !== cls || busy !== 1'b0) begin
      errors++;
      $display("FAIL result_latch: rv=%0b class=%0d busy=%0b want 1 %0d 0", result_valid, result_class, busy, cls);
    end
    exp_class = cls;
    @(posedge clk); #1;
    checks++;
    if (result_valid !== 1'b0 || result_class !== cls) begin
      errors++;
      $display("FAIL result_pulse: rv=%0b class=%0d want 0 %0d", result_valid, result_class, cls);
    end
  endtask

  function automatic logic [3:0] new_class();
    logic [3:0] c;
    c = 4'($urandom_range(1, 15));
    if (c == exp_class) c = c ^ 4'd1;
    return c;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (net_if.px_valid !== 1'b0 || net_if.px_last !== 1'b0 || net_if.px_data !== 16'h0 || net_if.px_idx !== 10'h0) begin
      errors++;
      $display("FAIL reset_bus: valid=%0b last=%0b data=%h idx=%0d want all 0",
               net_if.px_valid, net_if.px_last, net_if.px_data, net_if.px_idx);
    end
    checks++;
    if (busy !== 1'b0 || wr_drop !== 1'b0 || result_valid !== 1'b0 || result_class !== 4'd0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: busy=%0b drop=%0b rv=%0b class=%0d terr=%0b want all 0",
               busy, wr_drop, result_valid, result_class, timeout_err);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_stream_pattern();
    load_image(0);
    stream_check(0, 1'b0, 8'h00);
    test_result(4'd7, 20);
  endtask

  task automatic test_center();
    logic [15:0] lit [3];
`ifdef CRYSTAL_PIXEL_CENTER_EN
    lit[0] = 16'hFF80; lit[1] = 16'h0000; lit[2] = 16'h007F;
`else
    lit[0] = 16'h0000; lit[1] = 16'h0080; lit[2] = 16'h00FF;
`endif
    write_px(0, 8'd0);
    write_px(1, 8'd128);
    write_px(2, 8'd255);
    stream_check(0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cap[i] !== lit[i]) begin
        errors++;
        $display("FAIL center_px%0d: data=%h want %h", i, cap[i], lit[i]);
      end
    end
    test_result(new_class(), 5);
  endtask

  task automatic test_timeout();
    int  n;
    bit  saw_rv;
    n      = 0;
    saw_rv = 1'b0;
    stream_check(0, 1'b0, 8'h00);
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (result_valid === 1'b1) saw_rv = 1'b1;
      if (timeout_err === 1'b1) break;
    end
    checks++;
    if (n != TO) begin
      errors++;
      $display("FAIL timeout_cycles: timeout_err after %0d cycles want %0d", n, TO);
    end
    checks++;
    if (result_class !== exp_class || saw_rv || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_keep: class=%0d rv_seen=%0b busy=%0b want %0d 0 0", result_class, saw_rv, busy, exp_class);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: timeout_err=%0b want 1", timeout_err);
    end
    stream_check(0, 1'b0, 8'h00);
    test_result(new_class(), 3);
  endtask

  task automatic test_drops();
    write_px(800, 8'hA5);
    checks++;
    if (wr_drop !== 1'b1) begin
      errors++;
      $display("FAIL range_drop: wr_drop=%0b want 1", wr_drop);
    end
    @(posedge clk); #1;
    checks++;
    if (wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL drop_pulse: wr_drop=%0b want 0", wr_drop);
    end
    load_image(1);
    stream_check(1, 1'b0, 8'h00);
    test_result(new_class(), 10);
    stream_check(0, 1'b0, 8'h00);
    test_result(new_class(), 2);
  endtask

  task automatic test_start_with_write();
    logic [7:0] d;
    d = ~model[0];
    stream_check(0, 1'b1, d);
    test_result(new_class(), 4);
  endtask

  task automatic test_reset_mid_stream();
    stream_check(2, 1'b0, 8'h00);
    stream_check(0, 1'b0, 8'h00);
    test_result(new_class(), 6);
  endtask

  initial begin
    rst_n                 = 1'b0;
    img_wr_en             = 1'b0;
    img_wr_addr           = '0;
    img_wr_data           = '0;
    start                 = 1'b0;
    net_if.net_valid_out  = 1'b0;
    net_if.net_pred_class = 4'd0;
    exp_class             = 4'd0;
    test_reset();
    test_stream_pattern();
    test_center();
    test_timeout();
    test_drops();
    test_start_with_write();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
